// File: rtl/div_iter_core_if.sv
// Operand/result bundle between pre-conditioning, the iterative divider and the result mux.
// Latency: none, wires only.
// Backpressure: none; the driver watches busy, and ctrl_div while busy is dropped. data_remainder exists only with DIV_REMAINDER_EN.
interface div_iter_core_if #(
    parameter int WIDTH = 32
);
    logic             ctrl_div;
    logic [WIDTH-1:0] mag_dividend;
    logic [WIDTH-1:0] mag_divisor;
    logic             sign_dividend;
    logic             sign_divisor;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;
`ifdef DIV_REMAINDER_EN
    logic [WIDTH-1:0] data_remainder;
`endif

`ifdef DIV_REMAINDER_EN
    modport master (
        output ctrl_div, mag_dividend, mag_divisor, sign_dividend, sign_divisor,
        input  data_result, data_exception, data_resultRDY, busy, data_remainder
    );
    modport slave (
        input  ctrl_div, mag_dividend, mag_divisor, sign_dividend, sign_divisor,
        output data_result, data_exception, data_resultRDY, busy, data_remainder
    );
`else
    modport master (
        output ctrl_div, mag_dividend, mag_divisor, sign_dividend, sign_divisor,
        input  data_result, data_exception, data_resultRDY, busy
    );
    modport slave (
        input  ctrl_div, mag_dividend, mag_divisor, sign_dividend, sign_divisor,
        output data_result, data_exception, data_resultRDY, busy
    );
`endif
endinterface

// File: rtl/div_iter_core.sv
// Iterative restoring divider: unsigned magnitudes in, signed quotient + exception out (remainder with DIV_REMAINDER_EN).
// Latency: RDY in the cycle after WIDTH+1 edges from the start edge; 1 edge for divide-by-zero.
// Backpressure: ctrl_div is only sampled in IDLE; requests while busy are dropped, results held until the next start.
module div_iter_core #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6     // 2**CNT_W must exceed WIDTH
) (
    input  logic            clock,
    input  logic            reset_n,
    div_iter_core_if.slave  dif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;

    // Iteration state: partial remainder (one guard bit), shifting quotient, divisor, step count
    logic [WIDTH:0]     r_q;
    logic [WIDTH-1:0]   q_q;
    logic [WIDTH-1:0]   dvsr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               neg_q;

    // Held outputs
    logic [WIDTH-1:0]   res_q;
    logic               exc_q;
`ifdef DIV_REMAINDER_EN
    logic [WIDTH-1:0]   rem_q;
    logic               sgn_a_q;
`endif

    // Per-iteration combinational values
    logic [WIDTH+1:0]   ext;
    logic [WIDTH+1:0]   diff;
    logic [WIDTH:0]     r_nxt;
    logic [WIDTH-1:0]   q_nxt;
    logic [WIDTH-1:0]   q_signed;
    logic               ovf;

    logic               start;
    logic               div0;
    logic               last;

    // Control decode: accepted start, zero divisor, final iteration
    always_comb begin
        start = (state_q == S_IDLE) && dif.ctrl_div;
        div0  = (dif.mag_divisor == '0);
        last  = (state_q == S_RUN) && (cnt_q == CNT_W'(WIDTH - 1));
    end

    // One restoring step; the extra top bit of ext makes a borrow visible as diff's MSB
    always_comb begin
        ext  = {r_q, q_q[WIDTH-1]};
        diff = ext - {2'b00, dvsr_q};
        if (!diff[WIDTH+1]) begin
            r_nxt = diff[WIDTH:0];
            q_nxt = {q_q[WIDTH-2:0], 1'b1};
        end else begin
            r_nxt = ext[WIDTH:0];
            q_nxt = {q_q[WIDTH-2:0], 1'b0};
        end
        // A positive quotient with the top bit set only arises from most-negative / -1
        ovf = q_nxt[WIDTH-1] & ~neg_q;
        if (ovf) begin
            q_signed = {1'b1, {(WIDTH-1){1'b0}}};
        end else if (neg_q) begin
            q_signed = ~q_nxt + WIDTH'(1);
        end else begin
            q_signed = q_nxt;
        end
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (dif.ctrl_div) state_d = div0 ? S_DONE : S_RUN;
            S_RUN:   if (last) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from state only, so no input reaches an output combinationally
    always_comb begin
        dif.busy           = (state_q != S_IDLE);
        dif.data_resultRDY = (state_q == S_DONE);
    end

    // Iteration datapath: load on start, shift/subtract once per RUN cycle
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_q     <= '0;
            q_q     <= '0;
            dvsr_q  <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
`ifdef DIV_REMAINDER_EN
            sgn_a_q <= 1'b0;
`endif
        end else if (start) begin
            r_q     <= '0;
            q_q     <= dif.mag_dividend;
            dvsr_q  <= dif.mag_divisor;
            cnt_q   <= '0;
            neg_q   <= dif.sign_dividend ^ dif.sign_divisor;
`ifdef DIV_REMAINDER_EN
            sgn_a_q <= dif.sign_dividend;
`endif
        end else if (state_q == S_RUN) begin
            r_q     <= r_nxt;
            q_q     <= q_nxt;
            cnt_q   <= cnt_q + CNT_W'(1);
        end
    end

    // Result registers: written only on the edge entering DONE, held otherwise
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            res_q <= '0;
            exc_q <= 1'b0;
`ifdef DIV_REMAINDER_EN
            rem_q <= '0;
`endif
        end else if (start && div0) begin
            res_q <= '0;
            exc_q <= 1'b1;
`ifdef DIV_REMAINDER_EN
            rem_q <= dif.sign_dividend ? -dif.mag_dividend : dif.mag_dividend;
`endif
        end else if (last) begin
            res_q <= q_signed;
            exc_q <= ovf;
`ifdef DIV_REMAINDER_EN
            rem_q <= sgn_a_q ? -r_nxt[WIDTH-1:0] : r_nxt[WIDTH-1:0];
`endif
        end
    end

    assign dif.data_result    = res_q;
    assign dif.data_exception = exc_q;
`ifdef DIV_REMAINDER_EN
    assign dif.data_remainder = rem_q;
`endif

endmodule

// File: tb/tb_div_iter_core.sv
// Bench for div_iter_core: directed cases plus random signed operands against an arithmetic reference.
// Latency of each division is measured in edges from the start edge.
// Remainder checks are compiled in with DIV_REMAINDER_EN.
module tb_div_iter_core;

    logic clock;
    logic reset_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    div_iter_core_if #(.WIDTH(32)) dif ();

    div_iter_core #(.WIDTH(32), .CNT_W(6)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .dif     (dif)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: truncating signed division from magnitudes and signs
    task automatic model(input logic [31:0] ma, input logic [31:0] mb,
                         input logic sa, input logic sb,
                         output logic [31:0] res, output logic exc, output logic [31:0] rem);
        logic [31:0] q;
        logic [31:0] r;
        if (mb == 0) begin
            res = 0;
            exc = 1'b1;
            rem = sa ? -ma : ma;
        end else begin
            q = ma / mb;
            r = ma % mb;
            exc = q[31] && !(sa ^ sb);
            res = exc ? 32'h8000_0000 : ((sa ^ sb) ? -q : q);
            rem = sa ? -r : r;
        end
    endtask

    task automatic do_div(input logic [31:0] ma, input logic [31:0] mb,
                          input logic sa, input logic sb, input string tag);
        logic [31:0] e_res;
        logic [31:0] e_rem;
        logic        e_exc;
        int          edges;
        int          g;
        bit          got;
        model(ma, mb, sa, sb, e_res, e_exc, e_rem);
        g = 0;
        while (dif.busy !== 1'b0 && g < 100) begin
            @(negedge clock);
            g++;
        end
        @(negedge clock);
        dif.mag_dividend  = ma;
        dif.mag_divisor   = mb;
        dif.sign_dividend = sa;
        dif.sign_divisor  = sb;
        dif.ctrl_div      = 1'b1;
        edges = 0;
        got   = 0;
        while (!got && edges < 40) begin
            @(posedge clock);
            edges++;
            #1;
            if (edges == 1) dif.ctrl_div = 1'b0;
            if (dif.data_resultRDY === 1'b1) got = 1;
        end
        check({tag, "_lat"}, edges, (mb == 0) ? 32'd1 : 32'd33);
        check({tag, "_res"}, dif.data_result, e_res);
        check({tag, "_exc"}, {31'd0, dif.data_exception}, {31'd0, e_exc});
`ifdef DIV_REMAINDER_EN
        check({tag, "_rem"}, dif.data_remainder, e_rem);
`endif
        @(posedge clock);
        #1;
        check({tag, "_rdy_drop"}, {31'd0, dif.data_resultRDY}, 32'd0);
        check({tag, "_hold"}, dif.data_result, e_res);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        int          pulses;
        int          rdy_edge;
        int          rdy2_edge;

        reset_n           = 1'b0;
        dif.ctrl_div      = 1'b0;
        dif.mag_dividend  = '0;
        dif.mag_divisor   = '0;
        dif.sign_dividend = 1'b0;
        dif.sign_divisor  = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_res",  dif.data_result, 32'd0);
        check("rst_exc",  {31'd0, dif.data_exception}, 32'd0);
        check("rst_rdy",  {31'd0, dif.data_resultRDY}, 32'd0);
        check("rst_busy", {31'd0, dif.busy}, 32'd0);
        reset_n = 1'b1;

        // Directed cases
        do_div(32'd100, 32'd7, 1'b0, 1'b0, "p100d7");
        do_div(32'd100, 32'd7, 1'b1, 1'b0, "n100d7");
        do_div(32'd5,   32'd0, 1'b0, 1'b0, "div0");
        do_div(32'd20,  32'd4, 1'b0, 1'b0, "p20d4");
        do_div(32'h8000_0000, 32'd1, 1'b1, 1'b1, "ovf");
        do_div(32'h8000_0000, 32'd1, 1'b1, 1'b0, "minneg");

        // Extra requests while busy are dropped
        @(negedge clock);
        dif.mag_dividend  = 32'd1000;
        dif.mag_divisor   = 32'd3;
        dif.sign_dividend = 1'b0;
        dif.sign_divisor  = 1'b0;
        dif.ctrl_div      = 1'b1;
        pulses   = 0;
        rdy_edge = 0;
        for (int e = 1; e <= 34; e++) begin
            @(posedge clock);
            #1;
            if (dif.data_resultRDY === 1'b1) begin
                pulses++;
                rdy_edge = e;
            end
            dif.ctrl_div = (e == 4 || e == 19);
        end
        check("busy_pulses", pulses, 32'd1);
        check("busy_rdy_edge", rdy_edge, 32'd33);
        check("busy_res", dif.data_result, 32'd333);
        check("busy_idle", {31'd0, dif.busy}, 32'd0);

        // ctrl_div held high: back-to-back divisions, one IDLE cycle between
        @(negedge clock);
        dif.mag_dividend = 32'd50;
        dif.mag_divisor  = 32'd5;
        dif.ctrl_div     = 1'b1;
        rdy_edge  = 0;
        rdy2_edge = 0;
        for (int e = 1; e <= 80 && rdy2_edge == 0; e++) begin
            @(posedge clock);
            #1;
            if (dif.data_resultRDY === 1'b1) begin
                if (rdy_edge == 0) rdy_edge = e;
                else begin
                    rdy2_edge = e;
                    dif.ctrl_div = 1'b0;
                end
            end
        end
        dif.ctrl_div = 1'b0;
        check("hold_rdy1", rdy_edge, 32'd33);
        check("hold_rdy2", rdy2_edge, 32'd67);
        check("hold_res", dif.data_result, 32'd10);

        // Reset in the middle of a division
        do_div(32'd1000, 32'd3, 1'b0, 1'b0, "pre_rst");
        @(negedge clock);
        dif.mag_dividend = 32'd1000;
        dif.mag_divisor  = 32'd3;
        dif.ctrl_div     = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clock);
            #1;
            dif.ctrl_div = 1'b0;
        end
        reset_n = 1'b0;
        #1;
        check("mrst_res",  dif.data_result, 32'd0);
        check("mrst_exc",  {31'd0, dif.data_exception}, 32'd0);
        check("mrst_rdy",  {31'd0, dif.data_resultRDY}, 32'd0);
        check("mrst_busy", {31'd0, dif.busy}, 32'd0);
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        pulses = 0;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clock);
            #1;
            if (dif.data_resultRDY === 1'b1) pulses++;
        end
        check("mrst_no_rdy", pulses, 32'd0);
        do_div(32'd9, 32'd3, 1'b0, 1'b0, "post_rst");

        // Random signed operands converted to magnitude + sign
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = $urandom_range(1, 15);
                3:       begin a = 32'h8000_0000; b = $urandom_range(0, 1) ? 32'hFFFF_FFFF : $urandom; end
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            do_div(a[31] ? -a : a, b[31] ? -b : b, a[31], b[31], "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
